// File: rtl/uart_tx_mmio.sv
// rtl/uart_tx_mmio.sv - memory-mapped UART transmitter with TX FIFO and programmable divisor
// Optional even parity bit between data and stop when TX_PARITY_EN is defined.
module uart_tx_mmio #(
    parameter logic [31:0] ADDR_BASE   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd868
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_exec,
    input  logic        i_we,
    input  logic [2:0]  i_sel,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_data,
    output logic [31:0] o_data,
    output logic        o_fin,
    output logic        o_busy,
    output logic        o_tx
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {B_IDLE, B_FIN, B_STALL} bus_state_t;
    typedef enum logic [2:0] {
        T_IDLE, T_START, T_DATA, T_STOP
`ifdef TX_PARITY_EN
        , T_PARITY
`endif
    } tx_state_t;

    bus_state_t bus_state, bus_next;
    tx_state_t  tx_state, tx_next;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          full, empty;

    logic [15:0] div_reg, eff_div, frame_div, cnt;
    logic [2:0]  bit_idx;
    logic [7:0]  shreg, stall_data, push_data;
    logic        accept, in_win, wr_txdata, wr_div, push, pop, bit_end, tx_active;
    logic [1:0]  off;
    logic [31:0] rd_data;
    logic        unused_bits;
`ifdef TX_PARITY_EN
    logic        par_bit;
`endif

    assign unused_bits = ^{i_sel, i_addr[1:0], i_data[31:16]};

    assign full      = (count == CW'(FIFO_DEPTH));
    assign empty     = (count == '0);
    assign tx_active = (tx_state != T_IDLE);
    assign eff_div   = (div_reg == 16'd0) ? 16'd1 : div_reg;
    assign bit_end   = (cnt == 16'd1);

    assign in_win    = (i_addr[31:4] == ADDR_BASE[31:4]);
    assign off       = i_addr[3:2];
    assign accept    = i_exec & (bus_state == B_IDLE);
    assign wr_txdata = accept & i_we & in_win & (off == 2'd0);
    assign wr_div    = accept & i_we & in_win & (off == 2'd2);

    assign o_busy = (bus_state != B_IDLE);
    assign o_fin  = (bus_state == B_FIN);

    // A frame is pulled from the FIFO either from idle or straight out of the stop bit.
    assign pop  = ~empty & ((tx_state == T_IDLE) | ((tx_state == T_STOP) & bit_end));
    assign push = (wr_txdata & (~full | pop)) | ((bus_state == B_STALL) & pop);
    assign push_data = (bus_state == B_STALL) ? stall_data : i_data[7:0];

    always_comb begin
        rd_data = 32'h0;
        if (in_win && !i_we) begin
            case (off)
                2'd1:    rd_data = {16'h0, 8'(count), 5'h0, tx_active, empty, full};
                2'd2:    rd_data = {16'h0, div_reg};
                default: rd_data = 32'h0;
            endcase
        end
    end

    always_comb begin
        bus_next = bus_state;
        case (bus_state)
            B_IDLE:  if (accept) bus_next = (wr_txdata & full & ~pop) ? B_STALL : B_FIN;
            B_FIN:   bus_next = B_IDLE;
            B_STALL: if (pop) bus_next = B_FIN;
            default: bus_next = B_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            bus_state  <= B_IDLE;
            o_data     <= 32'h0;
            stall_data <= 8'h0;
            div_reg    <= DEFAULT_DIV;
        end else begin
            bus_state <= bus_next;
            o_data    <= accept ? rd_data : 32'h0;
            if (accept) stall_data <= i_data[7:0];
            if (wr_div) div_reg <= i_data[15:0];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            T_IDLE:  if (!empty) tx_next = T_START;
            T_START: if (bit_end) tx_next = T_DATA;
            T_DATA: begin
                if (bit_end && bit_idx == 3'd7) begin
`ifdef TX_PARITY_EN
                    tx_next = T_PARITY;
`else
                    tx_next = T_STOP;
`endif
                end
            end
`ifdef TX_PARITY_EN
            T_PARITY: if (bit_end) tx_next = T_STOP;
`endif
            T_STOP:  if (bit_end) tx_next = empty ? T_IDLE : T_START;
            default: tx_next = T_IDLE;
        endcase
    end

    always_comb begin
        o_tx = 1'b1;
        case (tx_state)
            T_START:  o_tx = 1'b0;
            T_DATA:   o_tx = shreg[0];
`ifdef TX_PARITY_EN
            T_PARITY: o_tx = par_bit;
`endif
            default:  o_tx = 1'b1;
        endcase
    end

    // The divisor is captured per frame so DIV writes only affect later frames.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            tx_state  <= T_IDLE;
            cnt       <= 16'd1;
            frame_div <= 16'd1;
            bit_idx   <= 3'd0;
            shreg     <= 8'h0;
`ifdef TX_PARITY_EN
            par_bit   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_next;
            if (pop) begin
                shreg     <= mem[rd_ptr];
                frame_div <= eff_div;
                cnt       <= eff_div;
                bit_idx   <= 3'd0;
`ifdef TX_PARITY_EN
                par_bit   <= ^mem[rd_ptr];
`endif
            end else if (tx_state != T_IDLE) begin
                if (bit_end) begin
                    cnt <= frame_div;
                    if (tx_state == T_DATA) begin
                        shreg   <= {1'b0, shreg[7:1]};
                        bit_idx <= bit_idx + 3'd1;
                    end
                end else begin
                    cnt <= cnt - 16'd1;
                end
            end
        end
    end
endmodule

// File: tb/tb_uart_tx_mmio.sv
// tb/tb_uart_tx_mmio.sv - randomized and directed bench for uart_tx_mmio against a queue/time model
module tb_uart_tx_mmio;
`ifdef TX_PARITY_EN
    localparam int LEN = 11;
`else
    localparam int LEN = 10;
`endif
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_exec = 1'b0, i_we = 1'b0;
    logic [2:0]  i_sel = 3'd0;
    logic [31:0] i_addr = 32'h0, i_data = 32'h0;
    logic [31:0] o_data;
    logic        o_fin, o_busy, o_tx;

    int tests = 0, fails = 0;
    bit cmp_en = 1'b0;

    uart_tx_mmio #(.ADDR_BASE(32'h1000_0000), .FIFO_DEPTH(DEPTH), .DEFAULT_DIV(16'd868)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_exec(i_exec), .i_we(i_we), .i_sel(i_sel),
        .i_addr(i_addr), .i_data(i_data), .o_data(o_data), .o_fin(o_fin), .o_busy(o_busy),
        .o_tx(o_tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            if (fails < 40) $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: FIFO as a queue, serial line as (frame bits, start time, bit period).
    logic [7:0]  mq[$];
    int          m_div = 868;
    int          m_bst = 0;          // 0 idle, 1 completing, 2 waiting for a free slot
    logic [7:0]  m_sb = 8'h0;
    logic [31:0] m_data = 32'h0;
    bit          m_act = 1'b0;
    logic [10:0] m_frame = 11'h7FF;
    int          m_fdiv = 1, m_fcyc = 0;

    function automatic logic [10:0] mk_frame(input logic [7:0] b);
`ifdef TX_PARITY_EN
        return {1'b1, ^b, b, 1'b0};
`else
        return {2'b01, b, 1'b0};
`endif
    endfunction

    task automatic model_step();
        int sz, new_div, off;
        bit pop, push, act_pre, inwin;
        logic [7:0] pdat;
        if (i_reset) begin
            mq.delete(); m_div = 868; m_bst = 0; m_data = 0; m_act = 0; m_fcyc = 0;
            return;
        end
        sz = mq.size(); act_pre = m_act; pop = 0; push = 0; pdat = 0; new_div = m_div;
        if (!m_act) pop = (sz > 0);
        else if (m_fcyc == LEN * m_fdiv - 1) begin
            pop = (sz > 0);
            if (!pop) m_act = 0;
        end else m_fcyc++;
        if (pop) begin
            m_act = 1; m_fcyc = 0; m_fdiv = (m_div == 0) ? 1 : m_div; m_frame = mk_frame(mq[0]);
        end
        m_data = 32'h0;
        if (m_bst == 1) m_bst = 0;
        else if (m_bst == 2) begin
            if (pop) begin push = 1; pdat = m_sb; m_bst = 1; end
        end else if (i_exec) begin
            inwin = (i_addr[31:4] == 28'h1000000);
            off = int'(i_addr[3:2]);
            m_bst = 1;
            if (i_we) begin
                if (inwin && off == 0) begin
                    if (sz < DEPTH || pop) begin push = 1; pdat = i_data[7:0]; end
                    else begin m_bst = 2; m_sb = i_data[7:0]; end
                end else if (inwin && off == 2) new_div = int'(i_data[15:0]);
            end else if (inwin && off == 1)
                m_data = {16'h0, 8'(sz), 5'h0, act_pre, (sz == 0), (sz == DEPTH)};
            else if (inwin && off == 2) m_data = m_div;
        end
        if (pop) void'(mq.pop_front());
        if (push) mq.push_back(pdat);
        m_div = new_div;
    endtask

    initial forever begin
        @(posedge clk or posedge i_reset);
        model_step();
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cyc_fin", {31'h0, o_fin}, {31'h0, m_bst == 1});
            chk("cyc_busy", {31'h0, o_busy}, {31'h0, m_bst != 0});
            chk("cyc_data", o_data, (m_bst == 1) ? m_data : 32'h0);
            chk("cyc_tx", {31'h0, o_tx}, {31'h0, m_act ? m_frame[m_fcyc / m_fdiv] : 1'b1});
        end
    end

    task automatic bus(input logic we, input logic [31:0] addr, input logic [31:0] wd,
                       output logic [31:0] rd, output int lat);
        int guard = 0;
        rd = 0; lat = 0;
        @(negedge clk);
        while (o_busy && guard < 2000) begin @(negedge clk); guard++; end
        if (guard >= 2000) chk("bus_idle_timeout", 32'h1, 32'h0);
        i_exec = 1'b1; i_we = we; i_addr = addr; i_data = wd; i_sel = 3'($urandom_range(0, 7));
        @(posedge clk); #1;
        i_exec = 1'b0;
        guard = 0;
        while (guard < 5000) begin
            @(negedge clk); lat++; guard++;
            if (o_fin) begin rd = o_data; break; end
        end
        if (guard >= 5000) chk("bus_fin_timeout", 32'h1, 32'h0);
    endtask

    task automatic wait_idle();
        logic [31:0] rd; int lat, n;
        for (n = 0; n < 2000; n++) begin
            bus(1'b0, 32'h1000_0004, 32'h0, rd, lat);
            if (rd == 32'h2) break;
        end
        if (n >= 2000) chk("drain_timeout", 32'h1, 32'h0);
    endtask

    task automatic wait_low();
        int g = 0;
        while (o_tx !== 1'b0 && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) chk("start_bit_timeout", 32'h1, 32'h0);
    endtask

    initial begin
        #900_000;
        $display("FAIL watchdog expired t=%0t", $time);
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        int lat, n, fin_cnt;
        bit prev_fin;
        logic [43:0] cap;
        logic [10:0] seq;
        logic [31:0] outside [4];

        outside[0] = 32'h1000_000C; outside[1] = 32'h2000_0000;
        outside[2] = 32'h1000_0010; outside[3] = 32'h0FFF_FFF8;

        repeat (3) @(negedge clk);
        cmp_en = 1'b1;
        i_reset = 1'b0;

        bus(1'b0, 32'h1000_0004, 32'h0, rd, lat);
        chk("reset_status", rd, 32'h0000_0002);
        chk("read_latency", lat, 1);
        bus(1'b0, 32'h1000_0008, 32'h0, rd, lat);
        chk("reset_div", rd, 32'd868);

        // 0xA5 at four clocks per bit
        bus(1'b1, 32'h1000_0008, 32'd4, rd, lat);
        bus(1'b1, 32'h1000_0000, 32'hFFFF_FFA5, rd, lat);
        chk("write_latency", lat, 1);
`ifdef TX_PARITY_EN
        seq = 11'b1_0_10100101_0;
`else
        seq = 11'b0_1_10100101_0;
`endif
        wait_low();
        cap = '0;
        cap[0] = o_tx;
        for (int i = 1; i < LEN * 4; i++) begin @(negedge clk); cap[i] = o_tx; end
        for (int s = 0; s < LEN; s++)
            chk($sformatf("a5_slot%0d", s), {28'h0, cap[s*4 +: 4]}, seq[s] ? 32'hF : 32'h0);

        // DIV=0 behaves as one clock per bit; a zero byte keeps the line low for start+data(+parity)
        bus(1'b1, 32'h1000_0008, 32'h0, rd, lat);
        bus(1'b0, 32'h1000_0008, 32'h0, rd, lat);
        chk("div0_readback", rd, 32'h0);
        bus(1'b1, 32'h1000_0000, 32'h0, rd, lat);
        wait_low();
        n = 1;
        while (n < 30) begin @(negedge clk); if (o_tx === 1'b0) n++; else break; end
        chk("div0_low_run", n, LEN - 1);

        bus(1'b0, 32'h1000_000C, 32'h0, rd, lat);
        chk("read_0c", rd, 32'h0);
        chk("read_0c_lat", lat, 1);
        bus(1'b0, 32'h2000_0000, 32'h0, rd, lat);
        chk("read_outside", rd, 32'h0);
        chk("read_outside_lat", lat, 1);

        // Request held high: one accept every other cycle
        @(negedge clk);
        i_exec = 1'b1; i_we = 1'b0; i_addr = 32'h1000_0004;
        fin_cnt = 0; prev_fin = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (o_fin && prev_fin) chk("fin_consecutive", 32'h1, 32'h0);
            if (o_fin) fin_cnt++;
            prev_fin = o_fin;
        end
        i_exec = 1'b0;
        chk("held_exec_fins", fin_cnt, 10);

        // Fill the FIFO behind a running frame; the ninth queued write must stall
        wait_idle();
        bus(1'b1, 32'h1000_0008, 32'd8, rd, lat);
        bus(1'b1, 32'h1000_0000, 32'h11, rd, lat);
        for (int i = 0; i < 9; i++) begin
            bus(1'b1, 32'h1000_0000, 32'($urandom_range(0, 255)), rd, lat);
            if (i < 8) chk("fill_lat", lat, 1);
        end
        chk("stall_held", {31'h0, lat >= 10}, 32'h1);
        bus(1'b1, 32'h1000_0008, 32'd1, rd, lat);
        wait_idle();

        // Random traffic
        for (int k = 0; k < 250; k++) begin
            case ($urandom_range(0, 5))
                0, 1: bus(1'b1, 32'h1000_0000, $urandom, rd, lat);
                2:    bus(1'b0, 32'h1000_0004, $urandom, rd, lat);
                3:    bus(1'b1, 32'h1000_0008, {$urandom_range(0, 65535), 16'($urandom_range(0, 3))}, rd, lat);
                4:    bus(1'b0, 32'h1000_0008, $urandom, rd, lat);
                default: bus(1'($urandom_range(0, 1)), outside[$urandom_range(0, 3)], $urandom, rd, lat);
            endcase
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        wait_idle();

        // Reset in the middle of a data bit with three bytes queued
        bus(1'b1, 32'h1000_0008, 32'd4, rd, lat);
        for (int i = 0; i < 4; i++) bus(1'b1, 32'h1000_0000, 32'h5A + i, rd, lat);
        wait_low();
        repeat (8) @(negedge clk);
        #2 i_reset = 1'b1;
        @(negedge clk);
        chk("reset_tx_high", {31'h0, o_tx}, 32'h1);
        chk("reset_not_busy", {31'h0, o_busy}, 32'h0);
        repeat (2) @(negedge clk);
        i_reset = 1'b0;
        bus(1'b0, 32'h1000_0004, 32'h0, rd, lat);
        chk("post_reset_status", rd, 32'h0000_0002);
        bus(1'b0, 32'h1000_0008, 32'h0, rd, lat);
        chk("post_reset_div", rd, 32'd868);
        n = 0;
        for (int i = 0; i < 100; i++) begin @(negedge clk); if (o_tx !== 1'b1) n++; end
        chk("post_reset_line_idle", n, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
